// File: rtl/alu_nbit_seq.sv
// Sequential N-bit ALU with valid/ready handshakes. Single-cycle logic/arith/shift
// ops; unsigned multiply by shift-add, one multiplier bit per cycle.
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             neg_flag,
  output logic             zero_flag,
  output logic             carry,
  output logic             ovf
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ov;
  } alu_out_t;

  state_t             state_q;
  state_t             state_d;
  logic [SH_W-1:0]    cnt_q;
  logic [WIDTH-1:0]   mcand_p1;
  logic [WIDTH-1:0]   acc_hi_p1;
  logic [WIDTH-1:0]   acc_lo_p1;
  logic               accept;
  logic               mul_last;
  alu_out_t           alu_p0;
  logic [2*WIDTH-1:0] prod_nxt;

  // Single-cycle operations. Signed overflow is read from the top two bits of a
  // sign-extended WIDTH+1 result, which cannot itself overflow.
  function automatic alu_out_t alu_eval(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y,
                                        input logic [2:0]       op);
    alu_out_t               r;
    logic [WIDTH:0]         uw;
    logic signed [WIDTH:0]  sx;
    logic signed [WIDTH:0]  sy;
    logic signed [WIDTH:0]  sw;
    logic [SH_W-1:0]        amt;
    r   = '0;
    uw  = '0;
    sx  = {x[WIDTH-1], x};
    sy  = {y[WIDTH-1], y};
    sw  = '0;
    amt = y[SH_W-1:0];
    case (op)
      OP_ADD: begin
        uw   = {1'b0, x} + {1'b0, y};
        sw   = sx + sy;
        r.res = uw[WIDTH-1:0];
        r.cy  = uw[WIDTH];
        r.ov  = sw[WIDTH] ^ sw[WIDTH-1];
      end
      OP_SUB: begin
        uw   = {1'b0, x} - {1'b0, y};
        sw   = sx - sy;
        r.res = uw[WIDTH-1:0];
        r.cy  = uw[WIDTH];
        r.ov  = sw[WIDTH] ^ sw[WIDTH-1];
      end
      OP_AND: r.res = x & y;
      OP_OR:  r.res = x | y;
      OP_XOR: r.res = x ^ y;
      OP_SHL: begin
        // Extra bit above the MSB catches the last bit shifted out.
        uw   = {1'b0, x} << amt;
        r.res = uw[WIDTH-1:0];
        r.cy  = uw[WIDTH];
      end
      OP_SHR: begin
        uw   = {x, 1'b0} >> amt;
        r.res = uw[WIDTH:1];
        r.cy  = uw[0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // One shift-add iteration: conditionally add the multiplicand into the high
  // half, then shift the whole partial product right by one.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] mc,
                                                  input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
    return {sum, lo[WIDTH-1:1]};
  endfunction

  always_comb begin
    alu_p0   = alu_eval(a, b, opcode);
    prod_nxt = mul_step(mcand_p1, acc_hi_p1, acc_lo_p1);
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    mul_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) state_d = (opcode == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        mul_last = (cnt_q == SH_W'(WIDTH - 1));
        if (mul_last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt_q <= '0;
    else if (accept)         cnt_q <= '0;
    else if (state_q == MUL) cnt_q <= cnt_q + SH_W'(1);
  end

  // p0 -> p1: operands captured at accept, so later input changes cannot
  // disturb a multiply in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p1  <= a;
      acc_hi_p1 <= '0;
      acc_lo_p1 <= b;
    end else if (state_q == MUL) begin
      {acc_hi_p1, acc_lo_p1} <= prod_nxt;
    end
  end

  // p1 -> outputs: results and flags registered together and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      neg_flag  <= 1'b0;
      zero_flag <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept && (opcode != OP_MUL)) begin
      result    <= alu_p0.res;
      result_hi <= '0;
      neg_flag  <= alu_p0.res[WIDTH-1];
      zero_flag <= (alu_p0.res == '0);
      carry     <= alu_p0.cy;
      ovf       <= alu_p0.ov;
    end else if (mul_last) begin
      result    <= prod_nxt[WIDTH-1:0];
      result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
      neg_flag  <= prod_nxt[2*WIDTH-1];
      zero_flag <= (prod_nxt == '0);
      carry     <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
      ovf       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq: driver pushes model results, monitor pops
// and compares on each presented output, plus directed handshake/reset cases.
module tb_alu_nbit_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   opcode = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         neg_flag;
  logic         zero_flag;
  logic         carry;
  logic         ovf;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flags;   // {neg, zero, carry, ovf}
    int           lat;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_drain_cyc = 0;
  int   last_acc_cyc = 0;
  bit   bp_rand = 1'b1;
  bit   or_force = 1'b1;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .neg_flag(neg_flag),
    .zero_flag(zero_flag), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_force;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definitions, using wide integers.
  function automatic exp_t model(input int op, input longint x, input longint y);
    exp_t   e;
    longint m    = longint'(1) << W;
    longint half = m / 2;
    longint sx   = (x >= half) ? x - m : x;
    longint sy   = (y >= half) ? y - m : y;
    longint s, sv, p, r, h;
    int     amt  = int'(y % W);
    bit     c = 0, v = 0, n, z;
    r = 0; h = 0; p = 0;
    case (op)
      0: begin s = x + y; r = s % m; c = (s >= m); sv = sx + sy; v = (sv < -half) || (sv >= half); end
      1: begin r = (x - y + m) % m; c = (x < y); sv = sx - sy; v = (sv < -half) || (sv >= half); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin r = (x << amt) % m; c = (amt != 0) && (((x >> (W - amt)) & 1) == 1); end
      6: begin r = x >> amt; c = (amt != 0) && (((x >> (amt - 1)) & 1) == 1); end
      default: begin p = x * y; r = p % m; h = p / m; c = (h != 0); end
    endcase
    n = (op == 7) ? (h >= half) : (r >= half);
    z = (op == 7) ? (p == 0) : (r == 0);
    e.res     = W'(r);
    e.hi      = W'(h);
    e.flags   = {n, z, c, v};
    e.lat     = (op == 7) ? W + 1 : 1;
    e.acc_cyc = 0;
    e.seen    = 1'b0;
    return e;
  endfunction

  // Monitor: checks handshake outputs every cycle and data against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
    end else begin
      check("in_ready", 64'(in_ready), 64'(q.size() == 0));
      if (q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else if (out_valid) begin
        if (!q[0].seen) begin
          check("latency", 64'(cyc - q[0].acc_cyc + 1), 64'(q[0].lat));
          q[0].seen = 1'b1;
        end
        check("result", 64'(result), 64'(q[0].res));
        check("result_hi", 64'(result_hi), 64'(q[0].hi));
        check("flags_nzco", 64'({neg_flag, zero_flag, carry, ovf}), 64'(q[0].flags));
        if (out_ready) begin
          void'(q.pop_front());
          last_drain_cyc = cyc + 1;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   waited = 0;
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(int'(op), longint'(x), longint'(y));
    e.acc_cyc = cyc;
    last_acc_cyc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    opcode   = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #1;
    check("reset_result", 64'(result), 64'(0));
    check("reset_result_hi", 64'(result_hi), 64'(0));
    check("reset_flags", 64'({neg_flag, zero_flag, carry, ovf}), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed corner cases
    drive_op(3'b000, 8'hFF, 8'h01);
    drive_op(3'b001, 8'h80, 8'h01);
    drive_op(3'b001, 8'h03, 8'h05);
    drive_op(3'b101, 8'h81, 8'h01);
    drive_op(3'b110, 8'h81, 8'h00);
    drive_op(3'b111, 8'hFF, 8'hFF);
    repeat (W + 2) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Output held under backpressure; pending input not taken until after drain.
    bp_rand  = 1'b0;
    or_force = 1'b0;
    @(posedge clk);
    #1;
    drive_op(3'b000, 8'h5A, 8'h3C);
    fork
      drive_op(3'b100, 8'hF0, 8'h0F);
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (3) @(negedge clk);
        or_force = 1'b1;
      end
    join
    check("accept_after_drain", 64'(last_acc_cyc >= last_drain_cyc + 1), 64'(1));
    bp_rand = 1'b1;
    wait_idle();

    // Reset in the middle of a multiply
    drive_op(3'b000, 8'h7F, 8'h01);
    wait_idle();
    drive_op(3'b111, 8'hC3, 8'h5B);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_result", 64'(result), 64'(0));
    check("async_rst_result_hi", 64'(result_hi), 64'(0));
    check("async_rst_flags", 64'({neg_flag, zero_flag, carry, ovf}), 64'(0));
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
    end

    // Randomized traffic with random backpressure and idle gaps
    for (int i = 0; i < 300; i++) begin
      logic [2:0]   op;
      logic [W-1:0] x, y;
      op = 3'($urandom_range(0, 7));
      x  = W'($urandom);
      y  = W'($urandom);
      case ($urandom_range(0, 9))
        0: x = '0;
        1: x = '1;
        2: y = '0;
        3: y = '1;
        default: ;
      endcase
      drive_op(op, x, y);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
